// File: rtl/generic_bus_sram_subordinate.sv
// Byte-strobed, word-addressed SRAM subordinate for the GenericBus with wait states and FIXED/INCR/WRAP bursts.
// Optional secure window: define GENERIC_SRAM_SUB_SECURE_EN to reject non-secure beats to the lowest SECURE_WORDS words.
module generic_bus_sram_subordinate #(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           DEPTH_WORDS  = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int unsigned           WAIT_STATES  = 1,
   parameter int unsigned           SECURE_WORDS = 16
) (
   input  logic                    clk,
   input  logic                    nReset,
   input  logic                    wEn,
   input  logic                    rEn,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH/8-1:0] wStrb,
   input  logic [DATA_WIDTH-1:0]   wData,
   input  logic                    isBurst,
   input  logic [1:0]              burstType,
   input  logic [7:0]              burstLen,
   input  logic                    nonSec,
   input  logic [2:0]              prot,
   output logic [DATA_WIDTH-1:0]   rData,
   output logic                    error,
   output logic                    busy
);

   localparam int unsigned           BYTES     = DATA_WIDTH / 8;
   localparam int unsigned           IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BYTES);
   localparam logic [ADDR_WIDTH:0]   WINDOW    = (ADDR_WIDTH+1)'(DEPTH_WORDS * BYTES);
   localparam logic [3:0]            WAIT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
   typedef enum logic [1:0] {B_FIXED = 2'd0, B_INCR = 2'd1, B_WRAP = 2'd2, B_RSVD = 2'd3} burst_e;

   state_e                  state_q;
   logic [3:0]              wait_cnt_q;
   logic [7:0]              beat_cnt_q;
   logic                    burst_active_q;
   logic [ADDR_WIDTH-1:0]   burst_start_q;
   logic [1:0]              burst_type_q;
   logic [7:0]              burst_len_q;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    error_q, error_d;
   logic [IDX_W-1:0]        idx_q;

   logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

   logic                    req, go_done;
   logic [ADDR_WIDTH-1:0]   eff_addr, step_off, wrap_mask, offset, word_idx_full;
   logic [1:0]              eff_type;
   logic [7:0]              eff_len;
   logic [8:0]              len_p1;
   logic                    range_err, burst_err, sec_err, beat_err;
   logic [IDX_W-1:0]        word_idx;

   assign req     = rEn | wEn;
   assign busy    = req && (state_q != S_DONE) && nReset;
   assign go_done = ((state_q == S_IDLE) && req && (WAIT_STATES == 0)) ||
                    ((state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST));

   // Follow-on burst beats ignore addr and regenerate it from the latched start.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      eff_addr  = addr;
      eff_type  = burstType;
      eff_len   = burstLen;
      step_off  = ADDR_WIDTH'(beat_cnt_q) * STEP;
      wrap_mask = ((ADDR_WIDTH'(burst_len_q) + ADDR_WIDTH'(1)) * STEP) - ADDR_WIDTH'(1);
      if (isBurst && burst_active_q) begin
         eff_type = burst_type_q;
         eff_len  = burst_len_q;
         case (burst_e'(burst_type_q))
            B_INCR:  eff_addr = burst_start_q + step_off;
            B_WRAP:  eff_addr = (burst_start_q & ~wrap_mask) | ((burst_start_q + step_off) & wrap_mask);
            default: eff_addr = burst_start_q;
         endcase
      end
   end

   assign offset        = eff_addr - BASE_ADDR;
   assign word_idx_full = offset / STEP;
   assign word_idx      = word_idx_full[IDX_W-1:0];
   assign len_p1        = {1'b0, eff_len} + 9'd1;
   assign range_err     = (eff_addr < BASE_ADDR) || ({1'b0, offset} >= WINDOW) ||
                          ((eff_addr % STEP) != '0);
   assign burst_err     = isBurst && ((eff_type == B_RSVD) ||
                          ((eff_type == B_WRAP) && ((len_p1 & (len_p1 - 9'd1)) != 9'd0)));
`ifdef GENERIC_SRAM_SUB_SECURE_EN
   assign sec_err       = nonSec && !range_err && (word_idx_full < ADDR_WIDTH'(SECURE_WORDS));
`else
   assign sec_err       = 1'b0;
`endif
   assign beat_err      = (rEn && wEn) || range_err || burst_err || sec_err;
   assign error_d       = beat_err;
   assign rdata_d       = (rEn && !beat_err) ? mem[word_idx] : '0;

   logic unused_ok;
   assign unused_ok = ^{prot, nonSec, word_idx_full};

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q        <= S_IDLE;
         wait_cnt_q     <= '0;
         beat_cnt_q     <= '0;
         burst_active_q <= 1'b0;
         burst_start_q  <= '0;
         burst_type_q   <= '0;
         burst_len_q    <= '0;
         rdata_q        <= '0;
         error_q        <= 1'b0;
         idx_q          <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  wait_cnt_q <= '0;
                  state_q    <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               wait_cnt_q <= wait_cnt_q + 4'd1;
               if (wait_cnt_q == WAIT_LAST) state_q <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               if (!isBurst) begin
                  burst_active_q <= 1'b0;
                  beat_cnt_q     <= '0;
               end else if (!burst_active_q) begin
                  if (burstLen != 8'd0) begin
                     burst_active_q <= 1'b1;
                     burst_start_q  <= addr;
                     burst_type_q   <= burstType;
                     burst_len_q    <= burstLen;
                     beat_cnt_q     <= 8'd1;
                  end
               end else if (beat_cnt_q == burst_len_q) begin
                  burst_active_q <= 1'b0;
                  beat_cnt_q     <= '0;
               end else begin
                  beat_cnt_q <= beat_cnt_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         if (go_done) begin
            rdata_q <= rdata_d;
            error_q <= error_d;
            idx_q   <= word_idx;
         end
      end
   end

   // NOTE: the array is deliberately left out of reset so it maps onto plain SRAM macros.
   always_ff @(posedge clk) begin
      if ((state_q == S_DONE) && wEn && !error_q) begin
         for (int i = 0; i < int'(BYTES); i++) begin
            if (wStrb[i]) mem[idx_q][8*i +: 8] <= wData[8*i +: 8];
         end
      end
   end

   assign rData = rdata_q;
   assign error = error_q;

endmodule

// File: tb/tb_generic_bus_sram_subordinate.sv
// Directed bench for generic_bus_sram_subordinate (32-bit data, 256 words, one wait state).
module tb_generic_bus_sram_subordinate;

   localparam int W = 1;

   logic        clk = 1'b0;
   logic        nReset;
   logic        wEn, rEn, isBurst, nonSec;
   logic [31:0] addr, wData;
   logic [3:0]  wStrb;
   logic [1:0]  burstType;
   logic [7:0]  burstLen;
   logic [2:0]  prot;
   logic [31:0] rData;
   logic        error, busy;

   logic [31:0] rd;
   logic        er;
   int          n_cmp = 0;
   int          n_mis = 0;

   generic_bus_sram_subordinate #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(256),
      .BASE_ADDR(32'h0), .WAIT_STATES(W), .SECURE_WORDS(16)
   ) dut (
      .clk(clk), .nReset(nReset), .wEn(wEn), .rEn(rEn), .addr(addr),
      .wStrb(wStrb), .wData(wData), .isBurst(isBurst), .burstType(burstType),
      .burstLen(burstLen), .nonSec(nonSec), .prot(prot),
      .rData(rData), .error(error), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one beat, counts busy cycles (bounded), samples the completion cycle.
   task automatic beat(input string tag, input logic we, input logic re, input logic [31:0] a,
                       input logic [3:0] strb, input logic [31:0] d, input logic isb,
                       input logic [1:0] bt, input logic [7:0] bl, input logic ns,
                       output logic [31:0] rdo, output logic ero);
      int n = 0;
      wEn = we; rEn = re; addr = a; wStrb = strb; wData = d;
      isBurst = isb; burstType = bt; burstLen = bl; nonSec = ns;
      while (n < 20) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      check({tag, "_lat"}, n, W + 1);
      rdo = rData;
      ero = error;
      @(posedge clk); #1;
      wEn = 1'b0; rEn = 1'b0; isBurst = 1'b0; nonSec = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
      logic [31:0] r;
      logic        e;
      beat(tag, 1'b1, 1'b0, a, strb, d, 1'b0, 2'd0, 8'd0, 1'b0, r, e);
      check({tag, "_err"}, e, 1'b0);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic exp_err);
      logic [31:0] r;
      logic        e;
      beat(tag, 1'b0, 1'b1, a, 4'h0, 32'h0, 1'b0, 2'd0, 8'd0, 1'b0, r, e);
      check({tag, "_data"}, r, exp);
      check({tag, "_err"}, e, exp_err);
   endtask

   initial begin
      nReset = 1'b0; wEn = 1'b0; rEn = 1'b0; addr = '0; wStrb = '0; wData = '0;
      isBurst = 1'b0; burstType = '0; burstLen = '0; nonSec = 1'b0; prot = 3'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_rdata", rData, 32'h0);
      nReset = 1'b1;
      @(posedge clk); #1;

      // Basic write/read and byte strobes
      wr("w10", 32'h10, 32'hDEADBEEF, 4'hF);
      rd_chk("r10", 32'h10, 32'hDEADBEEF, 1'b0);
      wr("w20", 32'h20, 32'h11223344, 4'hF);
      wr("w20b1", 32'h20, 32'h0000AA00, 4'h2);
      rd_chk("r20", 32'h20, 32'h1122AA44, 1'b0);
      wr("w10s0", 32'h10, 32'hFFFFFFFF, 4'h0);
      rd_chk("r10s0", 32'h10, 32'hDEADBEEF, 1'b0);

      // INCR write burst; addresses on beats 2..4 must be ignored
      for (int i = 0; i < 4; i++) begin
         beat("incr_w", 1'b1, 1'b0, (i == 0) ? 32'h40 : 32'h200 + 32'(i) * 4, 4'hF,
              32'(i + 1), 1'b1, 2'd1, 8'd3, 1'b0, rd, er);
         check("incr_w_err", er, 1'b0);
      end
      rd_chk("r40", 32'h40, 32'd1, 1'b0);
      rd_chk("r44", 32'h44, 32'd2, 1'b0);
      rd_chk("r48", 32'h48, 32'd3, 1'b0);
      rd_chk("r4c", 32'h4C, 32'd4, 1'b0);

      // WRAP burst from 0x38 over a 16-byte window: 0x38, 0x3C, 0x30, 0x34
      for (int i = 0; i < 4; i++) begin
         beat("wrap_w", 1'b1, 1'b0, 32'h38, 4'hF, 32'hA0 + 32'(i), 1'b1, 2'd2, 8'd3, 1'b0, rd, er);
         check("wrap_w_err", er, 1'b0);
      end
      rd_chk("r38", 32'h38, 32'hA0, 1'b0);
      rd_chk("r3c", 32'h3C, 32'hA1, 1'b0);
      rd_chk("r30", 32'h30, 32'hA2, 1'b0);
      rd_chk("r34", 32'h34, 32'hA3, 1'b0);

      // Error beats: same latency, rData 0, memory untouched
      rd_chk("r400", 32'h400, 32'h0, 1'b1);
      rd_chk("r02", 32'h02, 32'h0, 1'b1);
      beat("rw_both", 1'b1, 1'b1, 32'h10, 4'hF, 32'h0, 1'b0, 2'd0, 8'd0, 1'b0, rd, er);
      check("rw_both_err", er, 1'b1);
      check("rw_both_data", rd, 32'h0);
      beat("w400", 1'b1, 1'b0, 32'h400, 4'hF, 32'h12345678, 1'b0, 2'd0, 8'd0, 1'b0, rd, er);
      check("w400_err", er, 1'b1);
      rd_chk("r10_keep", 32'h10, 32'hDEADBEEF, 1'b0);
      beat("rsvd", 1'b0, 1'b1, 32'h40, 4'h0, 32'h0, 1'b1, 2'd3, 8'd0, 1'b0, rd, er);
      check("rsvd_err", er, 1'b1);
      beat("wrap3", 1'b0, 1'b1, 32'h40, 4'h0, 32'h0, 1'b1, 2'd2, 8'd2, 1'b0, rd, er);
      check("wrap3_err", er, 1'b1);
      rd_chk("r44_single", 32'h44, 32'd2, 1'b0);

      // INCR read burst running off the top of the window: beats 3 and 4 error
      for (int i = 0; i < 4; i++) begin
         beat("incr_oob", 1'b0, 1'b1, 32'h3F8, 4'h0, 32'h0, 1'b1, 2'd1, 8'd3, 1'b0, rd, er);
         check("incr_oob_err", er, (i >= 2) ? 1'b1 : 1'b0);
         if (i >= 2) check("incr_oob_data", rd, 32'h0);
      end
      rd_chk("r48_after", 32'h48, 32'd3, 1'b0);

      // Reset during the wait state of a write aborts it
      wr("w50", 32'h50, 32'h5555AAAA, 4'hF);
      rd_chk("r10_pre", 32'h10, 32'hDEADBEEF, 1'b0);
      wEn = 1'b1; rEn = 1'b0; addr = 32'h50; wStrb = 4'hF; wData = 32'hFFFFFFFF;
      @(negedge clk);
      check("abort_busy_idle", busy, 1'b1);
      @(posedge clk); #1;
      nReset = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_error", error, 1'b0);
      check("abort_rdata", rData, 32'h0);
      wEn = 1'b0;
      @(negedge clk);
      nReset = 1'b1;
      @(posedge clk); #1;
      rd_chk("r50_kept", 32'h50, 32'h5555AAAA, 1'b0);

      // Non-secure accesses to the low words
      beat("ns08", 1'b0, 1'b1, 32'h08, 4'h0, 32'h0, 1'b0, 2'd0, 8'd0, 1'b1, rd, er);
`ifdef GENERIC_SRAM_SUB_SECURE_EN
      check("ns08_err", er, 1'b1);
`else
      check("ns08_err", er, 1'b0);
`endif
      beat("ns100", 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 1'b0, 2'd0, 8'd0, 1'b1, rd, er);
      check("ns100_err", er, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
